load_store_unit: RTL and testbench

- Memory-access stage directly downstream of the execute stage in the multi-cycle RV32I core.
- Consumes the execute stage's effective address (address_o) and the rs2 value for stores.
- Runs one load or store on the word-wide data bus with a req/ack handshake.
- Returns a sign- or zero-extended load value to the writeback stage.
- Flags misaligned accesses and bus timeouts.

---
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 tb/tb_load_store_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage of the multi-cycle RV32I core.
// Runs one byte/halfword/word load or store over a word-wide req/ack bus,
// returns an extended load value and reports alignment faults and timeouts.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        is_store_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] address_i,
   input  logic [31:0] store_data_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_wstrb_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] load_data_o,
   output logic        done_o,
   output logic        busy_o,
   output logic        misaligned_o,
   output logic        bus_err_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [31:0]       r_addr;
   logic [2:0]        r_funct3;
   logic              r_isStore;
   logic [31:0]       r_wdata;
   logic [3:0]        r_wstrb;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_loadData;
   logic              r_misaligned;
   logic              r_busErr;

   logic              w_fault;
   logic [31:0]       w_wdata;
   logic [3:0]        w_wstrb;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_loadExt;
   logic [CNT_W-1:0]  w_cntNext;
   logic              w_timeout;

   // Decode the incoming request: legality/alignment, and the replicated
   // store data with its byte-lane strobes (strobes stay 0 for loads).
   always_comb begin
      w_fault = 1'b0;
      w_wdata = store_data_i;
      w_wstrb = 4'b0000;
      case (funct3_i)
         3'b000: begin
            if (is_store_i) begin
               w_wdata = {4{store_data_i[7:0]}};
               w_wstrb = 4'b0001 << address_i[1:0];
            end
         end
         3'b001: begin
            w_fault = address_i[0];
            if (is_store_i) begin
               w_wdata = {2{store_data_i[15:0]}};
               w_wstrb = address_i[1] ? 4'b1100 : 4'b0011;
            end
         end
         3'b010: begin
            w_fault = |address_i[1:0];
            if (is_store_i) begin
               w_wstrb = 4'b1111;
            end
         end
         3'b100:  w_fault = is_store_i;
         3'b101:  w_fault = is_store_i | address_i[0];
         default: w_fault = 1'b1;
      endcase
   end

   // Pick the addressed byte/halfword out of the read word and extend it.
   always_comb begin
      case (r_addr[1:0])
         2'd0:    w_byte = mem_rdata_i[7:0];
         2'd1:    w_byte = mem_rdata_i[15:8];
         2'd2:    w_byte = mem_rdata_i[23:16];
         default: w_byte = mem_rdata_i[31:24];
      endcase
      w_half = r_addr[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      case (r_funct3)
         3'b000:  w_loadExt = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_loadExt = {{16{w_half[15]}}, w_half};
         3'b100:  w_loadExt = {24'd0, w_byte};
         3'b101:  w_loadExt = {16'd0, w_half};
         default: w_loadExt = mem_rdata_i;
      endcase
   end

   assign w_cntNext = r_cnt + CNT_W'(1);
   assign w_timeout = (w_cntNext == CNT_W'(TIMEOUT_CYCLES));

   // Access sequencer: latch the request, wait for ack or timeout, then
   // present a single-cycle completion with its fault qualifiers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= IDLE;
         r_addr       <= 32'd0;
         r_funct3     <= 3'd0;
         r_isStore    <= 1'b0;
         r_wdata      <= 32'd0;
         r_wstrb      <= 4'd0;
         r_cnt        <= '0;
         r_loadData   <= 32'd0;
         r_misaligned <= 1'b0;
         r_busErr     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_misaligned <= 1'b0;
               r_busErr     <= 1'b0;
               r_cnt        <= '0;
               if (start_i) begin
                  r_addr    <= address_i;
                  r_funct3  <= funct3_i;
                  r_isStore <= is_store_i;
                  r_wdata   <= w_wdata;
                  r_wstrb   <= w_wstrb;
                  if (w_fault) begin
                     r_misaligned <= 1'b1;
                     r_state      <= DONE;
                  end else begin
                     r_state <= REQ;
                  end
               end
            end
            REQ: begin
               if (mem_ack_i) begin
                  if (!r_isStore) begin
                     r_loadData <= w_loadExt;
                  end
                  r_cnt   <= '0;
                  r_state <= DONE;
               end else if (w_timeout) begin
                  r_busErr <= 1'b1;
                  r_cnt    <= '0;
                  r_state  <= DONE;
               end else begin
                  r_cnt <= w_cntNext;
               end
            end
            DONE: begin
               r_misaligned <= 1'b0;
               r_busErr     <= 1'b0;
               r_state      <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_req_o    = (r_state == REQ);
   assign mem_we_o     = (r_state == REQ) & r_isStore;
   assign mem_wstrb_o  = (r_state == REQ) ? r_wstrb : 4'b0000;
   assign mem_addr_o   = {r_addr[31:2], 2'b00};
   assign mem_wdata_o  = r_wdata;
   assign load_data_o  = r_loadData;
   assign done_o       = (r_state == DONE);
   assign busy_o       = (r_state != IDLE);
   assign misaligned_o = (r_state == DONE) & r_misaligned;
   assign bus_err_o    = (r_state == DONE) & r_busErr;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed test of load_store_unit. Expected completions
// are queued when an access is issued and checked by a monitor on done_o.
module tb_load_store_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        is_store_i;
   logic [2:0]  funct3_i;
   logic [31:0] address_i;
   logic [31:0] store_data_i;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_wstrb_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic [31:0] load_data_o;
   logic        done_o;
   logic        busy_o;
   logic        misaligned_o;
   logic        bus_err_o;

   typedef struct packed {
      logic        mis;
      logic        berr;
      logic [31:0] data;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;

   load_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .is_store_i(is_store_i),
      .funct3_i(funct3_i), .address_i(address_i), .store_data_i(store_data_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i), .load_data_o(load_data_o), .done_o(done_o),
      .busy_o(busy_o), .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
   );

   // 10 ns clock
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Pulse start_i for one cycle; returns 1 ns after the sampling edge.
   task automatic applyStimulus(input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] data);
      is_store_i   = st;
      funct3_i     = f3;
      address_i    = addr;
      store_data_i = data;
      start_i      = 1'b1;
      @(posedge clk_i); #1;
      start_i      = 1'b0;
   endtask

   task automatic ackCycle(input logic [31:0] rdata);
      mem_rdata_i = rdata;
      mem_ack_i   = 1'b1;
      @(posedge clk_i); #1;
      mem_ack_i   = 1'b0;
   endtask

   task automatic nextCycle();
      @(posedge clk_i); #1;
   endtask

   // Monitor: every completion must match the oldest queued expectation,
   // and the fault qualifiers must stay low outside completions.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (done_o) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_done: got done_o=1 expected no completion");
            end else begin
               exp_t e;
               e = expQ.pop_front();
               checkOutput("mon_misaligned", misaligned_o, e.mis);
               checkOutput("mon_bus_err", bus_err_o, e.berr);
               checkOutput("mon_load_data", load_data_o, e.data);
            end
         end else begin
            checkOutput("mon_flags_idle", {misaligned_o, bus_err_o}, 0);
         end
      end
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      rst_i = 1'b1; start_i = 1'b0; is_store_i = 1'b0; funct3_i = 3'd0;
      address_i = 32'd0; store_data_i = 32'd0; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("rst_req", mem_req_o, 0);
      checkOutput("rst_busy", busy_o, 0);
      checkOutput("rst_done", done_o, 0);
      checkOutput("rst_load_data", load_data_o, 0);
      checkOutput("rst_addr", mem_addr_o, 0);
      checkOutput("rst_wdata", mem_wdata_o, 0);
      checkOutput("rst_wstrb", mem_wstrb_o, 0);
      rst_i = 1'b0;
      nextCycle();

      $display("[TB] LB sign-extended byte");
      expQ.push_back(exp_t'{mis: 1'b0, berr: 1'b0, data: 32'hFFFFFF80});
      applyStimulus(1'b0, 3'b000, 32'h0000_1003, 32'd0);
      checkOutput("lb_req", mem_req_o, 1);
      checkOutput("lb_addr", mem_addr_o, 32'h0000_1000);
      checkOutput("lb_wstrb", mem_wstrb_o, 0);
      checkOutput("lb_we", mem_we_o, 0);
      checkOutput("lb_busy", busy_o, 1);
      ackCycle(32'h8011_2233);
      checkOutput("lb_done_n2", done_o, 1);
      checkOutput("lb_req_done", mem_req_o, 0);
      nextCycle();
      checkOutput("lb_idle_busy", busy_o, 0);

      $display("[TB] LHU / LH / LBU");
      expQ.push_back(exp_t'{mis: 1'b0, berr: 1'b0, data: 32'h0000BEEF});
      applyStimulus(1'b0, 3'b101, 32'h0000_2002, 32'd0);
      checkOutput("lhu_addr", mem_addr_o, 32'h0000_2000);
      ackCycle(32'hBEEF_1234);
      nextCycle();
      expQ.push_back(exp_t'{mis: 1'b0, berr: 1'b0, data: 32'hFFFFBEEF});
      applyStimulus(1'b0, 3'b001, 32'h0000_2002, 32'd0);
      ackCycle(32'hBEEF_1234);
      nextCycle();
      expQ.push_back(exp_t'{mis: 1'b0, berr: 1'b0, data: 32'h00000022});
      applyStimulus(1'b0, 3'b100, 32'h0000_1001, 32'd0);
      ackCycle(32'h8011_2233);
      nextCycle();

      $display("[TB] SB with delayed ack");
      expQ.push_back(exp_t'{mis: 1'b0, berr: 1'b0, data: 32'h00000022});
      applyStimulus(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5);
      for (int i = 0; i < 3; i++) begin
         checkOutput("sb_req", mem_req_o, 1);
         checkOutput("sb_we", mem_we_o, 1);
         checkOutput("sb_wstrb", mem_wstrb_o, 4'b0010);
         checkOutput("sb_wdata", mem_wdata_o, 32'hA5A5A5A5);
         checkOutput("sb_addr", mem_addr_o, 32'h0000_3000);
         if (i == 2) ackCycle(32'hFFFF_FFFF);
         else nextCycle();
      end
      checkOutput("sb_done", done_o, 1);
      nextCycle();

      $display("[TB] SH upper half");
      expQ.push_back(exp_t'{mis: 1'b0, berr: 1'b0, data: 32'h00000022});
      applyStimulus(1'b1, 3'b001, 32'h0000_3802, 32'h1234_5678);
      checkOutput("sh_wstrb", mem_wstrb_o, 4'b1100);
      checkOutput("sh_wdata", mem_wdata_o, 32'h5678_5678);
      ackCycle(32'd0);
      nextCycle();

      $display("[TB] misaligned SW then LW");
      expQ.push_back(exp_t'{mis: 1'b1, berr: 1'b0, data: 32'h00000022});
      applyStimulus(1'b1, 3'b010, 32'h0000_4002, 32'hDEAD_BEEF);
      checkOutput("sw_mis_req", mem_req_o, 0);
      checkOutput("sw_mis_done_n1", done_o, 1);
      nextCycle();
      expQ.push_back(exp_t'{mis: 1'b0, berr: 1'b0, data: 32'hCAFEF00D});
      applyStimulus(1'b0, 3'b010, 32'h0000_4000, 32'd0);
      checkOutput("lw_req", mem_req_o, 1);
      checkOutput("lw_addr", mem_addr_o, 32'h0000_4000);
      ackCycle(32'hCAFE_F00D);
      nextCycle();

      $display("[TB] illegal LBU-as-store");
      expQ.push_back(exp_t'{mis: 1'b1, berr: 1'b0, data: 32'hCAFEF00D});
      applyStimulus(1'b1, 3'b100, 32'h0000_4000, 32'd0);
      checkOutput("ill_req", mem_req_o, 0);
      nextCycle();

      $display("[TB] LW timeout");
      expQ.push_back(exp_t'{mis: 1'b0, berr: 1'b1, data: 32'hCAFEF00D});
      applyStimulus(1'b0, 3'b010, 32'h0000_5000, 32'd0);
      n = 0;
      while (mem_req_o && n < 10) begin
         n++;
         nextCycle();
      end
      checkOutput("to_req_cycles", n, 4);
      checkOutput("to_done", done_o, 1);
      checkOutput("to_bus_err", bus_err_o, 1);
      nextCycle();

      $display("[TB] reset during REQ");
      applyStimulus(1'b0, 3'b010, 32'h0000_6000, 32'd0);
      nextCycle();
      rst_i   = 1'b1;
      start_i = 1'b1;
      nextCycle();
      rst_i   = 1'b0;
      start_i = 1'b0;
      checkOutput("rr_req", mem_req_o, 0);
      checkOutput("rr_busy", busy_o, 0);
      checkOutput("rr_done", done_o, 0);
      checkOutput("rr_load_data", load_data_o, 0);
      nextCycle();
      checkOutput("rr_start_ignored", busy_o, 0);

      $display("[TB] start during REQ ignored");
      expQ.push_back(exp_t'{mis: 1'b0, berr: 1'b0, data: 32'h12345678});
      applyStimulus(1'b0, 3'b010, 32'h0000_7000, 32'd0);
      is_store_i = 1'b1;
      address_i  = 32'h0000_8000;
      start_i    = 1'b1;
      nextCycle();
      start_i    = 1'b0;
      checkOutput("sr_req", mem_req_o, 1);
      checkOutput("sr_addr", mem_addr_o, 32'h0000_7000);
      checkOutput("sr_we", mem_we_o, 0);
      ackCycle(32'h1234_5678);
      checkOutput("sr_done", done_o, 1);
      nextCycle();
      checkOutput("sr_idle", busy_o, 0);

      repeat (2) nextCycle();
      checkOutput("queue_empty", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
